// File: rtl/reg_scoreboard.sv
// Register scoreboard with a bypassing register file.
// Each architectural register carries a small counter of in-flight writers; issue is
// held off while any source still has an outstanding writer or while the destination's
// counter would overflow. Writebacks retire reservations, update the register file and
// are forwarded to same-cycle source reads.
module reg_scoreboard #(
    parameter int unsigned       NREGS   = 17,
    parameter int unsigned       WIDTH   = 64,
    parameter int unsigned       NSRC    = 3,
    parameter int unsigned       NWB     = 2,
    parameter int unsigned       CNTW    = 2,
    parameter int unsigned       SP_IDX  = 4,
    parameter logic [WIDTH-1:0]  SP_INIT = 64'h7C00,
    localparam int unsigned      IDXW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iss_valid,
    output logic                   iss_ready,
    input  logic [NSRC-1:0]        iss_src_valid,
    input  logic [NSRC*IDXW-1:0]   iss_src_idx,
    input  logic                   iss_dst_valid,
    input  logic [IDXW-1:0]        iss_dst_idx,
    output logic [NSRC*WIDTH-1:0]  iss_src_data,
    input  logic [NWB-1:0]         wb_valid,
    input  logic [NWB*IDXW-1:0]    wb_idx,
    input  logic [NWB*WIDTH-1:0]   wb_data,
    input  logic                   flush,
    output logic [NREGS-1:0]       busy,
    output logic                   wb_err
);

    localparam int MAXCNT = (1 << CNTW) - 1;

    logic [CNTW-1:0]  cnt_q [NREGS];
    logic [CNTW-1:0]  cnt_d [NREGS];
    logic [WIDTH-1:0] rf_q  [NREGS];
    logic [WIDTH-1:0] rf_d  [NREGS];
    logic             wb_err_q;
    logic             wb_err_d;

    logic [IDXW-1:0]  wbi   [NWB];
    logic [WIDTH-1:0] wbd   [NWB];
    logic [NWB-1:0]   wb_inr;
    logic [IDXW-1:0]  srci  [NSRC];
    logic [NSRC-1:0]  src_inr;
    logic             dst_inr;
    int               hits  [NREGS];
    int               eff   [NREGS];
    logic             fire;

    // Unpack flat index/data buses and flag in-range indices.
    always_comb begin
        wb_inr  = '0;
        src_inr = '0;
        for (int p = 0; p < NWB; p++) begin
            wbi[p]    = wb_idx[p*IDXW +: IDXW];
            wbd[p]    = wb_data[p*WIDTH +: WIDTH];
            wb_inr[p] = (int'(wbi[p]) < int'(NREGS));
        end
        for (int s = 0; s < NSRC; s++) begin
            srci[s]    = iss_src_idx[s*IDXW +: IDXW];
            src_inr[s] = (int'(srci[s]) < int'(NREGS));
        end
        dst_inr = (int'(iss_dst_idx) < int'(NREGS));
    end

    // Per-register writeback hit count and effective (post-writeback) writer count.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            hits[r] = 0;
            for (int p = 0; p < NWB; p++) begin
                if (wb_valid[p] && wb_inr[p] && int'(wbi[p]) == r) begin
                    hits[r] = hits[r] + 1;
                end
            end
            eff[r] = (int'(cnt_q[r]) > hits[r]) ? int'(cnt_q[r]) - hits[r] : 0;
        end
    end

    // Issue readiness: sources must be settled and the destination counter must have room.
    always_comb begin
        iss_ready = !flush;
        for (int s = 0; s < NSRC; s++) begin
            if (iss_src_valid[s] && src_inr[s] && eff[srci[s]] != 0) begin
                iss_ready = 1'b0;
            end
        end
        if (iss_dst_valid && dst_inr && eff[iss_dst_idx] >= MAXCNT) begin
            iss_ready = 1'b0;
        end
    end

    // Source operand read with forwarding; the highest-numbered matching port wins.
    always_comb begin
        iss_src_data = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (iss_src_valid[s]) begin
                if (src_inr[s]) begin
                    iss_src_data[s*WIDTH +: WIDTH] = rf_q[srci[s]];
                end
                for (int p = 0; p < NWB; p++) begin
                    if (wb_valid[p] && wb_inr[p] && wbi[p] == srci[s]) begin
                        iss_src_data[s*WIDTH +: WIDTH] = wbd[p];
                    end
                end
            end
        end
    end

    // Next-state for register file, writer counters and the sticky error flag.
    always_comb begin
        fire     = iss_valid && iss_ready;
        wb_err_d = wb_err_q;
        for (int r = 0; r < NREGS; r++) begin
            rf_d[r] = rf_q[r];
            for (int p = 0; p < NWB; p++) begin
                if (wb_valid[p] && wb_inr[p] && int'(wbi[p]) == r) begin
                    rf_d[r] = wbd[p];
                end
            end
            if (flush) begin
                cnt_d[r] = '0;
            end else begin
                // eff < MAXCNT whenever an issue targets r, so this cannot wrap.
                cnt_d[r] = CNTW'(eff[r] +
                    ((fire && iss_dst_valid && int'(iss_dst_idx) == r) ? 1 : 0));
            end
            // More writebacks than reservations means at least one was unreserved.
            if (!flush && hits[r] > int'(cnt_q[r])) begin
                wb_err_d = 1'b1;
            end
        end
        for (int p = 0; p < NWB; p++) begin
            if (!flush && wb_valid[p] && !wb_inr[p]) begin
                wb_err_d = 1'b1;
            end
        end
    end

    // State registers; reset restores the stack pointer and drops all reservations.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
                rf_q[r]  <= (r == int'(SP_IDX)) ? SP_INIT : '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
                rf_q[r]  <= rf_d[r];
            end
            wb_err_q <= wb_err_d;
        end
    end

    // Busy mirrors the stored counters only.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
        wb_err = wb_err_q;
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_reg_scoreboard;

    localparam int NREGS = 17;
    localparam int WIDTH = 64;
    localparam int NSRC  = 3;
    localparam int NWB   = 2;
    localparam int IDXW  = 5;
    localparam int MAXC  = 3;
    localparam int SPI   = 4;
    localparam logic [63:0] SPV = 64'h7C00;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  iss_valid;
    logic                  iss_ready;
    logic [NSRC-1:0]       iss_src_valid;
    logic [NSRC*IDXW-1:0]  iss_src_idx;
    logic                  iss_dst_valid;
    logic [IDXW-1:0]       iss_dst_idx;
    logic [NSRC*WIDTH-1:0] iss_src_data;
    logic [NWB-1:0]        wb_valid;
    logic [NWB*IDXW-1:0]   wb_idx;
    logic [NWB*WIDTH-1:0]  wb_data;
    logic                  flush;
    logic [NREGS-1:0]      busy;
    logic                  wb_err;

    logic [IDXW-1:0] sidx [NSRC];
    logic [IDXW-1:0] widx [NWB];
    logic [63:0]     wdat [NWB];

    // Behavioural model state.
    int          mcnt [NREGS];
    logic [63:0] mrf  [NREGS];
    bit          merr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        iss_src_idx = '0;
        wb_idx      = '0;
        wb_data     = '0;
        for (int s = 0; s < NSRC; s++) iss_src_idx[s*IDXW +: IDXW] = sidx[s];
        for (int p = 0; p < NWB; p++) begin
            wb_idx[p*IDXW +: IDXW]    = widx[p];
            wb_data[p*WIDTH +: WIDTH] = wdat[p];
        end
    end

    reg_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_src_valid (iss_src_valid),
        .iss_src_idx   (iss_src_idx),
        .iss_dst_valid (iss_dst_valid),
        .iss_dst_idx   (iss_dst_idx),
        .iss_src_data  (iss_src_data),
        .wb_valid      (wb_valid),
        .wb_idx        (wb_idx),
        .wb_data       (wb_data),
        .flush         (flush),
        .busy          (busy),
        .wb_err        (wb_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_src_valid = '0; iss_dst_valid = 1'b0; iss_dst_idx = '0;
        wb_valid = '0; flush = 1'b0;
        for (int s = 0; s < NSRC; s++) sidx[s] = '0;
        for (int p = 0; p < NWB; p++) begin widx[p] = '0; wdat[p] = '0; end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            mcnt[r] = 0;
            mrf[r]  = (r == SPI) ? SPV : 64'h0;
        end
        merr = 1'b0;
    endtask

    // Outstanding writers per register left after this cycle's writebacks retire.
    function automatic int pending(input int r);
        int n;
        n = mcnt[r];
        for (int p = 0; p < NWB; p++) if (wb_valid[p] && int'(widx[p]) == r) n--;
        return n;
    endfunction

    function automatic bit model_ready();
        bit rdy;
        rdy = !flush;
        for (int s = 0; s < NSRC; s++)
            if (iss_src_valid[s] && int'(sidx[s]) < NREGS && pending(int'(sidx[s])) > 0) rdy = 0;
        if (iss_dst_valid && int'(iss_dst_idx) < NREGS && pending(int'(iss_dst_idx)) >= MAXC)
            rdy = 0;
        return rdy;
    endfunction

    // The compare process: every output against the model for the current inputs.
    task automatic compare_model();
        logic [63:0]      d;
        logic [NREGS-1:0] eb;
        chk("ready", 64'(iss_ready), 64'(model_ready()));
        for (int s = 0; s < NSRC; s++) begin
            d = 64'h0;
            if (iss_src_valid[s]) begin
                if (int'(sidx[s]) < NREGS) d = mrf[sidx[s]];
                for (int p = 0; p < NWB; p++)
                    if (wb_valid[p] && int'(widx[p]) < NREGS && widx[p] == sidx[s]) d = wdat[p];
            end
            chk($sformatf("src_data%0d", s), iss_src_data[s*WIDTH +: WIDTH], d);
        end
        for (int r = 0; r < NREGS; r++) eb[r] = (mcnt[r] != 0);
        chk("busy", 64'(busy), 64'(eb));
        chk("wb_err", 64'(wb_err), 64'(merr));
    endtask

    task automatic model_tick();
        int h [NREGS];
        bit fire;
        int c;
        fire = iss_valid && model_ready();
        for (int r = 0; r < NREGS; r++) h[r] = 0;
        for (int p = 0; p < NWB; p++) begin
            if (wb_valid[p]) begin
                if (int'(widx[p]) < NREGS) begin
                    mrf[widx[p]] = wdat[p];
                    h[widx[p]]++;
                end else if (!flush) begin
                    merr = 1'b1;
                end
            end
        end
        for (int r = 0; r < NREGS; r++) begin
            if (!flush && h[r] > mcnt[r]) merr = 1'b1;
            if (flush) begin
                mcnt[r] = 0;
            end else begin
                c = mcnt[r] - h[r];
                if (c < 0) c = 0;
                if (fire && iss_dst_valid && int'(iss_dst_idx) == r) c++;
                mcnt[r] = c;
            end
        end
    endtask

    task automatic eval();
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic issue_dst(input int r);
        idle();
        iss_valid = 1'b1; iss_dst_valid = 1'b1; iss_dst_idx = IDXW'(r);
        eval();
        tick();
    endtask

    task automatic random_cycle(input bit allow_err);
        int avail [NREGS];
        int r;
        idle();
        iss_valid     = ($urandom % 4) != 0;
        iss_src_valid = NSRC'($urandom);
        for (int s = 0; s < NSRC; s++) sidx[s] = IDXW'($urandom % NREGS);
        iss_dst_valid = ($urandom % 3) != 0;
        iss_dst_idx   = IDXW'($urandom % NREGS);
        for (int i = 0; i < NREGS; i++) avail[i] = mcnt[i];
        for (int p = 0; p < NWB; p++) begin
            wdat[p] = {$urandom, $urandom};
            if (allow_err && ($urandom % 10) == 0) begin
                wb_valid[p] = 1'b1;
                widx[p]     = IDXW'($urandom % 32);
            end else if (($urandom % 3) != 0) begin
                r = int'($urandom % NREGS);
                for (int k = 0; k < NREGS; k++) begin
                    if (!wb_valid[p] && avail[(r + k) % NREGS] > 0) begin
                        wb_valid[p] = 1'b1;
                        widx[p]     = IDXW'((r + k) % NREGS);
                        avail[(r + k) % NREGS]--;
                    end
                end
            end
        end
        if (allow_err) flush = ($urandom % 20) == 0;
        eval();
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        // Reset state, including combinational outputs while reset is held.
        #12;
        iss_src_valid = 3'b001; sidx[0] = IDXW'(SPI);
        eval();
        chk("rst_ready", 64'(iss_ready), 64'h1);
        chk("rst_sp", iss_src_data[63:0], 64'h7C00);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err", 64'(wb_err), 64'h0);
        reset = 1'b1;

        // Stack pointer read after reset.
        iss_valid = 1'b1;
        eval();
        chk("sp_ready", 64'(iss_ready), 64'h1);
        chk("sp_data", iss_src_data[63:0], 64'h7C00);
        chk("sp_busy", 64'(busy), 64'h0);
        tick();

        // Fill reg 1 to its writer limit, then relieve it with a same-cycle writeback.
        for (int i = 0; i < 3; i++) issue_dst(1);
        idle();
        iss_valid = 1'b1; iss_dst_valid = 1'b1; iss_dst_idx = 5'd1;
        eval();
        chk("r1_busy", 64'(busy[1]), 64'h1);
        chk("r1_full", 64'(iss_ready), 64'h0);
        wb_valid = 2'b01; widx[0] = 5'd1; wdat[0] = 64'h11;
        eval();
        chk("r1_relief", 64'(iss_ready), 64'h1);
        tick();

        // Forwarding of a same-cycle writeback to a pending source.
        issue_dst(2);
        idle();
        iss_valid = 1'b1; iss_src_valid = 3'b001; sidx[0] = 5'd2;
        wb_valid = 2'b01; widx[0] = 5'd2; wdat[0] = 64'hDEAD;
        eval();
        chk("fwd_ready", 64'(iss_ready), 64'h1);
        chk("fwd_data", iss_src_data[63:0], 64'hDEAD);
        tick();
        idle();
        eval();
        chk("r2_free", 64'(busy[2]), 64'h0);

        // Two ports writing the same register: higher port wins, both retire.
        issue_dst(3);
        issue_dst(3);
        idle();
        wb_valid = 2'b11; widx[0] = 5'd3; wdat[0] = 64'd5; widx[1] = 5'd3; wdat[1] = 64'd9;
        eval();
        tick();
        idle();
        iss_src_valid = 3'b001; sidx[0] = 5'd3;
        eval();
        chk("dual_data", iss_src_data[63:0], 64'd9);
        chk("dual_busy", 64'(busy[3]), 64'h0);
        chk("dual_err", 64'(wb_err), 64'h0);

        // Flush clears reservations; a late writeback afterwards is an error.
        issue_dst(2);
        idle();
        flush = 1'b1; iss_valid = 1'b1; iss_dst_valid = 1'b1; iss_dst_idx = 5'd5;
        eval();
        chk("flush_ready", 64'(iss_ready), 64'h0);
        tick();
        idle();
        eval();
        chk("flush_busy", 64'(busy), 64'h0);
        wb_valid = 2'b01; widx[0] = 5'd1; wdat[0] = 64'h77;
        eval();
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("late_err", 64'(wb_err), 64'h1);
            tick();
        end

        // Out-of-range writeback, then asynchronous reset in the middle of a cycle.
        reset = 1'b0;
        #1;
        model_reset();
        reset = 1'b1;
        idle();
        wb_valid = 2'b10; widx[1] = 5'd17; wdat[1] = 64'hBAD;
        eval();
        tick();
        idle();
        iss_src_valid = 3'b001; sidx[0] = IDXW'(SPI);
        eval();
        chk("oor_err", 64'(wb_err), 64'h1);
        chk("oor_sp", iss_src_data[63:0], 64'h7C00);
        reset = 1'b0;
        #1;
        chk("async_err", 64'(wb_err), 64'h0);
        model_reset();
        compare_model();
        reset = 1'b1;
        tick();

        // Random traffic with only reserved writebacks.
        for (int i = 0; i < 2000; i++) random_cycle(1'b0);

        // Random traffic with flushes, stray writebacks and occasional mid-cycle resets.
        for (int i = 0; i < 2000; i++) begin
            if (($urandom % 150) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                compare_model();
                reset = 1'b1;
                #1;
            end
            random_cycle(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
